// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and counter sizing shared by the register FIFO.
package fifo_pkg;
  localparam string FWFT_TRUE = "TRUE";
  localparam string FWFT_FALSE = "FALSE";
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: FIFO pointer with enable and synchronous clear, wrapping at DEPTH-1.
module fifo_ptr_wrap #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (en) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_single_clock_reg_v2.sv
// fifo_single_clock_reg_v2: register FIFO with any depth, programmable level flags,
// synchronous flush, sticky overflow/underflow and normal or first-word-fall-through reads.
module fifo_single_clock_reg_v2
  import fifo_pkg::*;
#(
  parameter string FWFT_MODE = FWFT_FALSE,
  parameter int DEPTH = 8,
  parameter int DATA_W = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              w_req,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_req,
  output logic [DATA_W-1:0] r_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              ovf,
  output logic              unf,
  input  logic              err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam bit FWFT = (FWFT_MODE == FWFT_TRUE);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  logic [CNT_W-1:0] cnt_nxt;
  assign rd_acc = r_req && !empty && !flush;
  // a full FIFO still takes a write when the same cycle frees a slot
  assign wr_acc = w_req && (!full || rd_acc) && !flush;
  assign cnt_nxt = flush ? '0 : cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .nrst(nrst), .clr(flush), .en(wr_acc), .ptr(wr_ptr));
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .nrst(nrst), .clr(flush), .en(rd_acc), .ptr(rd_ptr));
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= w_data;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cnt <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= (AE_LEVEL >= 0);
      almost_full <= (AF_LEVEL <= 0);
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full <= (32'(cnt_nxt) == DEPTH);
      almost_empty <= (32'(cnt_nxt) <= AE_LEVEL);
      almost_full <= (32'(cnt_nxt) >= AF_LEVEL);
      ovf <= (ovf && !err_clr) || (w_req && !wr_acc && !flush);
      unf <= (unf && !err_clr) || (r_req && !rd_acc && !flush);
    end
  // in FWFT mode r_q tracks the presented head so an emptied FIFO keeps showing it
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_q <= '0;
    else if (FWFT ? !empty : rd_acc) r_q <= mem[rd_ptr];
  assign r_data = (FWFT && !empty) ? mem[rd_ptr] : r_q;
endmodule

// File: tb/tb_fifo_single_clock_reg_v2.sv
// tb_fifo_single_clock_reg_v2: a DEPTH=5 normal-mode and a DEPTH=8 FWFT FIFO share one
// directed stimulus and are checked every cycle against queue models plus literal expectations.
module tb_fifo_single_clock_reg_v2;
  logic clk = 0, nrst = 0, flush = 0, w_req = 0, r_req = 0, err_clr = 0;
  logic [15:0] w_data = '0;
  logic [15:0] r_data0, r_data1;
  logic [2:0] cnt0;
  logic [3:0] cnt1;
  logic empty0, full0, ae0, af0, ovf0, unf0;
  logic empty1, full1, ae1, af1, ovf1, unf1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fifo_single_clock_reg_v2 #(.FWFT_MODE("FALSE"), .DEPTH(5), .DATA_W(16)) dut0 (
    .clk(clk), .nrst(nrst), .flush(flush), .w_req(w_req), .w_data(w_data), .r_req(r_req),
    .r_data(r_data0), .cnt(cnt0), .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .ovf(ovf0), .unf(unf0), .err_clr(err_clr));

  fifo_single_clock_reg_v2 #(.FWFT_MODE("TRUE"), .DEPTH(8), .DATA_W(16), .AF_LEVEL(6), .AE_LEVEL(2)) dut1 (
    .clk(clk), .nrst(nrst), .flush(flush), .w_req(w_req), .w_data(w_data), .r_req(r_req),
    .r_data(r_data1), .cnt(cnt1), .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .ovf(ovf1), .unf(unf1), .err_clr(err_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // queue models: index 0 is the DEPTH=5 normal FIFO, index 1 the DEPTH=8 FWFT FIFO
  int dep [2] = '{5, 8};
  bit fw [2] = '{1'b0, 1'b1};
  int afl [2] = '{4, 6};
  int ael [2] = '{1, 2};
  logic [15:0] q [2][$];
  logic [15:0] last [2];
  logic [15:0] rdn [2];
  bit eo [2], eu [2];
  bit m_rd, m_wr;
  int m_n;
  logic [15:0] m_v;

  always @(posedge clk or negedge nrst)
    for (int i = 0; i < 2; i++)
      if (!nrst) begin
        q[i].delete();
        last[i] = '0;
        rdn[i] = '0;
        eo[i] = 0;
        eu[i] = 0;
      end else begin
        m_n = q[i].size();
        if (fw[i] && m_n > 0) last[i] = q[i][0];
        m_rd = !flush && r_req && m_n > 0;
        m_wr = !flush && w_req && (m_n < dep[i] || m_rd);
        eo[i] = (eo[i] && !err_clr) || (!flush && w_req && !m_wr);
        eu[i] = (eu[i] && !err_clr) || (!flush && r_req && !m_rd);
        if (m_rd) begin
          m_v = q[i].pop_front();
          if (!fw[i]) rdn[i] = m_v;
        end
        if (m_wr) q[i].push_back(w_data);
        if (flush) q[i].delete();
      end

  function automatic logic [15:0] exp_rd(input int i);
    if (!fw[i]) return rdn[i];
    return (q[i].size() > 0) ? q[i][0] : last[i];
  endfunction

  always @(negedge clk) begin
    chk("d0.cnt", 32'(cnt0), q[0].size());
    chk("d0.empty", 32'(empty0), 32'(q[0].size() == 0));
    chk("d0.full", 32'(full0), 32'(q[0].size() == dep[0]));
    chk("d0.ae", 32'(ae0), 32'(q[0].size() <= ael[0]));
    chk("d0.af", 32'(af0), 32'(q[0].size() >= afl[0]));
    chk("d0.ovf", 32'(ovf0), 32'(eo[0]));
    chk("d0.unf", 32'(unf0), 32'(eu[0]));
    chk("d0.r_data", 32'(r_data0), 32'(exp_rd(0)));
    chk("d1.cnt", 32'(cnt1), q[1].size());
    chk("d1.empty", 32'(empty1), 32'(q[1].size() == 0));
    chk("d1.full", 32'(full1), 32'(q[1].size() == dep[1]));
    chk("d1.ae", 32'(ae1), 32'(q[1].size() <= ael[1]));
    chk("d1.af", 32'(af1), 32'(q[1].size() >= afl[1]));
    chk("d1.ovf", 32'(ovf1), 32'(eo[1]));
    chk("d1.unf", 32'(unf1), 32'(eu[1]));
    chk("d1.r_data", 32'(r_data1), 32'(exp_rd(1)));
  end

  task automatic cyc(input bit w, input logic [15:0] d, input bit r, input bit f = 0, input bit e = 0);
    w_req = w;
    w_data = d;
    r_req = r;
    flush = f;
    err_clr = e;
    @(posedge clk);
    #1;
    w_req = 0;
    r_req = 0;
    flush = 0;
    err_clr = 0;
  endtask

  initial begin
    #12;
    chk("rst.cnt", 32'(cnt0), 0);
    chk("rst.empty", 32'(empty0), 1);
    chk("rst.full", 32'(full0), 0);
    chk("rst.ae", 32'(ae0), 1);
    chk("rst.af", 32'(af0), 0);
    chk("rst.r_data", 32'(r_data0), 0);
    #5 nrst = 1;
    for (int k = 1; k <= 5; k++) cyc(1, 16'(k), 0);
    chk("fill.full", 32'(full0), 1);
    chk("fill.cnt", 32'(cnt0), 5);
    chk("fill.af", 32'(af0), 1);
    chk("fill.d1_af", 32'(af1), 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, '0, 1);
      chk("drain.r_data", 32'(r_data0), k);
      chk("drain.d1_r_data", 32'(r_data1), (k < 5) ? k + 1 : 5);
    end
    chk("drain.empty", 32'(empty0), 1);
    chk("drain.d1_empty", 32'(empty1), 1);
    cyc(0, '0, 0, 1);
    cyc(1, 16'hABCD, 0);
    chk("fwft.empty", 32'(empty1), 0);
    chk("fwft.r_data", 32'(r_data1), 32'hABCD);
    cyc(0, '0, 1);
    chk("fwft.pop_empty", 32'(empty1), 1);
    chk("fwft.hold", 32'(r_data1), 32'hABCD);
    chk("norm.r_data", 32'(r_data0), 32'hABCD);
    for (int k = 0; k < 5; k++) cyc(1, 16'(16'h10 + k), 0);
    cyc(1, 16'h15, 1);
    chk("wr_rd_full.cnt", 32'(cnt0), 5);
    chk("wr_rd_full.ovf", 32'(ovf0), 0);
    chk("wr_rd_full.r_data", 32'(r_data0), 32'h10);
    cyc(1, 16'h16, 0);
    chk("ovf.set", 32'(ovf0), 1);
    chk("ovf.cnt", 32'(cnt0), 5);
    cyc(0, '0, 0);
    chk("ovf.sticky", 32'(ovf0), 1);
    cyc(0, '0, 0, 0, 1);
    chk("ovf.clr", 32'(ovf0), 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1);
    chk("unf.set", 32'(unf0), 1);
    chk("unf.cnt", 32'(cnt0), 0);
    cyc(0, '0, 1, 0, 1);
    chk("unf.clr_and_set", 32'(unf0), 1);
    cyc(0, '0, 0, 0, 1);
    chk("unf.clr", 32'(unf0), 0);
    for (int k = 0; k < 23; k++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      chk("sweep.cnt_le_5", 32'(cnt0 <= 3'd5), 1);
    end
    cyc(0, '0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 16'(16'h30 + k), 0);
    chk("pre_flush.cnt", 32'(cnt0), 3);
    cyc(1, 16'h55, 0, 1);
    chk("flush.cnt", 32'(cnt0), 0);
    chk("flush.empty", 32'(empty0), 1);
    cyc(1, 16'h77, 0);
    cyc(0, '0, 1);
    chk("post_flush.r_data", 32'(r_data0), 32'h77);
    cyc(1, 16'h88, 0);
    cyc(1, 16'h99, 0);
    nrst = 0;
    #2;
    chk("arst.cnt", 32'(cnt0), 0);
    chk("arst.empty", 32'(empty0), 1);
    chk("arst.r_data", 32'(r_data0), 0);
    chk("arst.d1_r_data", 32'(r_data1), 0);
    chk("arst.d1_empty", 32'(empty1), 1);
    #1 nrst = 1;
    cyc(1, 16'h1234, 0);
    cyc(0, '0, 1);
    chk("after_rst.r_data", 32'(r_data0), 32'h1234);
    cyc(0, '0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
